// File: rtl/flit_route.sv
// Wormhole flit router: 2-entry input skid buffer, head-flit destination decode, route held until tail.
// Front flit presented one cycle after accept; input ready is registered and drops only when both skid entries are full.
module flit_route #(
  parameter int NPORT   = 4,
  parameter int DST_LSB = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 Valid_i,
  input  logic [31:0]          Data_i,
  output logic                 Ready_o,
  output logic [NPORT-1:0]     Valid_o,
  output logic [32*NPORT-1:0]  Data_o,
  input  logic [NPORT-1:0]     Ready_i,
  output logic                 Error_o,
  output logic [7:0]           DropCnt_o
);

  localparam int DW = $clog2(NPORT);
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t        r_state;
  logic [DW-1:0] r_route;
  logic [31:0]   r_buf0;
  logic [31:0]   r_buf1;
  logic [1:0]    r_cnt;
  logic          r_rdy;
  logic          r_err;
  logic [7:0]    r_drop_cnt;

  logic          w_have;
  logic          w_head;
  logic          w_tail;
  logic [DW-1:0] w_dst;
  logic          w_dst_ok;
  logic          w_out_vld;
  logic [DW-1:0] w_lane;
  logic          w_drop;
  logic          w_fire;
  logic          w_err;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_cnt_nxt;

  assign w_have   = (r_cnt != 2'd0);
  assign w_head   = (r_buf0[31:30] == T_HEAD);
  assign w_tail   = (r_buf0[31:30] == T_TAIL);
  assign w_dst    = r_buf0[DST_LSB +: DW];
  assign w_dst_ok = (32'(w_dst) < $unsigned(NPORT));

  // Decision is made on the front flit only; drops never wait for a lane ready.
  always_comb begin
    w_out_vld = 1'b0;
    w_lane    = '0;
    w_drop    = 1'b0;
    if (w_have) begin
      case (r_state)
        S_IDLE: begin
          if (w_head && w_dst_ok) begin
            w_out_vld = 1'b1;
            w_lane    = w_dst;
          end else begin
            w_drop = 1'b1;
          end
        end
        S_FWD: begin
          w_out_vld = 1'b1;
          w_lane    = r_route;
        end
        S_DROP:  w_drop = 1'b1;
        default: w_drop = 1'b0;
      endcase
    end
  end

  assign Valid_o = w_out_vld ? ({{(NPORT-1){1'b0}}, 1'b1} << w_lane) : '0;
  assign w_fire  = |(Valid_o & Ready_i);
  assign w_err   = (w_drop && (r_state == S_IDLE)) ||
                   ((r_state == S_FWD) && w_fire && w_head);
  assign w_pop   = w_fire | w_drop;
  assign w_push  = Valid_i & r_rdy;

  always_comb begin
    Data_o = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (Valid_o[p]) Data_o[32*p +: 32] = r_buf0;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 2'd1;
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - 2'd1;
  end

  // Ready is precomputed from the next occupancy so it never sees Ready_i combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_cnt      <= '0;
      r_rdy      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      if (w_pop) begin
        r_buf0 <= r_buf1;
        if (w_push) begin
          if (r_cnt == 2'd1) r_buf0 <= Data_i;
          else               r_buf1 <= Data_i;
        end
      end else if (w_push) begin
        if (r_cnt == 2'd0) r_buf0 <= Data_i;
        else               r_buf1 <= Data_i;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_route <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_route <= w_dst;
            r_state <= S_FWD;
          end else if (w_drop && w_head) begin
            r_state <= S_DROP;
          end
        end
        S_FWD:   if (w_fire && w_tail) r_state <= S_IDLE;
        S_DROP:  if (w_drop && w_tail) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Ready_o   = r_rdy;
  assign Error_o   = r_err;
  assign DropCnt_o = r_drop_cnt;

endmodule

// File: tb/tb_flit_route.sv
// Bench for flit_route: cycle table for the basic packet and stray cases, stream runs scored against a packet-level model.
module tb_flit_route;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         Valid_i;
  logic [31:0]  Data_i;
  logic         Ready_o;
  logic [3:0]   Valid_o;
  logic [127:0] Data_o;
  logic [3:0]   Ready_i;
  logic         Error_o;
  logic [7:0]   DropCnt_o;

  logic         v3_i;
  logic [31:0]  d3_i;
  logic         rdy3_o;
  logic [2:0]   vld3_o;
  logic [95:0]  dat3_o;
  logic [2:0]   rdy3_i;
  logic         err3_o;
  logic [7:0]   cnt3_o;

  flit_route #(.NPORT(4), .DST_LSB(0)) dut (
    .clk(clk), .rstn(rstn), .Valid_i(Valid_i), .Data_i(Data_i), .Ready_o(Ready_o),
    .Valid_o(Valid_o), .Data_o(Data_o), .Ready_i(Ready_i), .Error_o(Error_o),
    .DropCnt_o(DropCnt_o));

  flit_route #(.NPORT(3), .DST_LSB(0)) dut3 (
    .clk(clk), .rstn(rstn), .Valid_i(v3_i), .Data_i(d3_i), .Ready_o(rdy3_o),
    .Valid_o(vld3_o), .Data_o(dat3_o), .Ready_i(rdy3_i), .Error_o(err3_o),
    .DropCnt_o(cnt3_o));

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic [3:0]  rdy;
    logic        e_rdy;
    logic [3:0]  e_vld;
    logic [31:0] e_dat;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  typedef struct { int lane; logic [31:0] dat; int cyc; } rx_t;
  typedef struct { int lane; logic [31:0] dat; } exp_t;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] tx_q[$];
  logic [31:0] acc_q[$];
  rx_t         rx_q[$];
  int          errs, n_notready, onehot_bad;
  int          m_mode, m_route, mdl_drop;

  vec_t        tbl[9];
  logic [127:0] exp_bus;
  logic [31:0] f3[5];
  int          k3, e3, vcyc3, nd3;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Drives tx_q into the 4-lane DUT and records every lane fire and every accepted flit.
  task automatic run_stream(input string tag, input int stall_lo, input int stall_hi,
                            input logic [3:0] stall_mask, input bit rnd);
    int cyc;
    int idle;
    logic [3:0] rdy;
    logic vld;
    rx_t r;
    cyc = 0; idle = 0;
    rx_q.delete(); acc_q.delete();
    errs = 0; n_notready = 0; onehot_bad = 0;
    while ((tx_q.size() != 0 || idle < 8) && cyc < 3000) begin
      @(negedge clk);
      rdy = (rnd && $urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (cyc >= stall_lo && cyc <= stall_hi) rdy = rdy & ~stall_mask;
      vld = (tx_q.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      Valid_i = vld;
      Data_i  = vld ? tx_q[0] : 32'h0;
      Ready_i = rdy;
      #1;
      if (Error_o) errs++;
      if ($countones(Valid_o) > 1) onehot_bad++;
      for (int p = 0; p < 4; p++) begin
        if (Valid_o[p] && Ready_i[p]) begin
          r.lane = p; r.dat = Data_o[32*p +: 32]; r.cyc = cyc;
          rx_q.push_back(r);
        end
      end
      if (vld && Ready_o) acc_q.push_back(tx_q.pop_front());
      if (vld && !Ready_o) n_notready++;
      if (tx_q.size() == 0 && Valid_o == 4'h0) idle++;
      else idle = 0;
      cyc++;
    end
    chk({tag, "_drained"}, tx_q.size(), 0);
  endtask

  // Packet-level reference: walks the accepted stream and predicts lane deliveries, errors and drops.
  task automatic model_check(input string tag);
    exp_t exp_q[$];
    exp_t e;
    int e_err;
    logic [31:0] f;
    logic [1:0] t;
    int d;
    e_err = 0;
    foreach (acc_q[i]) begin
      f = acc_q[i];
      t = f[31:30];
      d = int'(f[1:0]);
      if (m_mode == 0) begin
        if (t == 2'b00 && d < 4) begin
          e.lane = d; e.dat = f; exp_q.push_back(e);
          m_route = d; m_mode = 1;
        end else begin
          e_err++;
          if (mdl_drop < 255) mdl_drop++;
          if (t == 2'b00) m_mode = 2;
        end
      end else if (m_mode == 1) begin
        e.lane = m_route; e.dat = f; exp_q.push_back(e);
        if (t == 2'b00) e_err++;
        if (t == 2'b11) m_mode = 0;
      end else begin
        if (mdl_drop < 255) mdl_drop++;
        if (t == 2'b11) m_mode = 0;
      end
    end
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_flit%0d", tag, i), {32'(rx_q[i].lane), rx_q[i].dat},
          {32'(exp_q[i].lane), exp_q[i].dat});
    chk({tag, "_errors"}, errs, e_err);
    chk({tag, "_dropcnt"}, DropCnt_o, mdl_drop);
    chk({tag, "_onehot"}, onehot_bad, 0);
  endtask

  task automatic gen_random(input int n);
    logic [31:0] w;
    int r, nb;
    while (tx_q.size() < n) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r == 0) begin
        tx_q.push_back({($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11, w[29:0]});
      end else begin
        tx_q.push_back({2'b00, w[29:0]});
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          w = $urandom;
          tx_q.push_back({($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, w[29:0]});
        end
        if (r != 1) begin
          w = $urandom;
          tx_q.push_back({2'b11, w[29:0]});
        end
      end
    end
  endtask

  initial begin
    //        vld   dat            rdy   e_rdy e_vld  e_dat          e_err e_cnt
    tbl[0] = '{1'b1, 32'h0000_0002, 4'hF, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 32'h4000_0000, 4'hF, 1'b1, 4'h4, 32'h0000_0002, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 32'hC000_0000, 4'hF, 1'b1, 4'h4, 32'h4000_0000, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 32'h0000_0000, 4'hF, 1'b1, 4'h4, 32'hC000_0000, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 32'h4000_0005, 4'hF, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 32'h0000_0001, 4'hF, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 8'd0};
    tbl[6] = '{1'b1, 32'hC000_0011, 4'hF, 1'b1, 4'h2, 32'h0000_0001, 1'b1, 8'd1};
    tbl[7] = '{1'b0, 32'h0000_0000, 4'hF, 1'b1, 4'h2, 32'hC000_0011, 1'b0, 8'd1};
    tbl[8] = '{1'b0, 32'h0000_0000, 4'hF, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 8'd1};

    rstn = 1'b0; Valid_i = 1'b1; Data_i = 32'h0000_0002; Ready_i = 4'hF;
    v3_i = 1'b0; d3_i = 32'h0; rdy3_i = 3'b111;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", Ready_o, 1'b0);
      chk("rst_valid", Valid_o, 4'h0);
      chk("rst_dropcnt", DropCnt_o, 8'h0);
      chk("rst_error", Error_o, 1'b0);
    end
    rstn = 1'b1; Valid_i = 1'b0;
    @(negedge clk);
    chk("rel_ready", Ready_o, 1'b1);
    chk("rel_valid", Valid_o, 4'h0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_bus = '0;
      for (int p = 0; p < 4; p++) if (tbl[i].e_vld[p]) exp_bus[32*p +: 32] = tbl[i].e_dat;
      chk($sformatf("tbl%0d_ready", i), Ready_o, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_valid", i), Valid_o, tbl[i].e_vld);
      chk($sformatf("tbl%0d_data", i), Data_o, exp_bus);
      chk($sformatf("tbl%0d_error", i), Error_o, tbl[i].e_err);
      chk($sformatf("tbl%0d_dropcnt", i), DropCnt_o, tbl[i].e_cnt);
      Valid_i = tbl[i].vld; Data_i = tbl[i].dat; Ready_i = tbl[i].rdy;
    end
    mdl_drop = 1; m_mode = 0; m_route = 0;

    // Lane 2 stalls for five cycles right after the head is buffered.
    tx_q = '{32'h0000_0A02, 32'h4000_0011, 32'h8000_0012, 32'h4000_0013,
             32'h8000_0014, 32'hC000_0015};
    run_stream("stall", 1, 5, 4'b0100, 1'b0);
    chk("stall_notready_cycles", n_notready, 5);
    model_check("stall");

    tx_q = '{32'h0000_0001, 32'h4000_0101, 32'hC000_0102, 32'h0000_0003, 32'hC000_0203,
             32'h0000_0302, 32'h4000_0301, 32'h0000_0401, 32'h8000_0402, 32'hC000_0403};
    run_stream("b2b", -1, -2, 4'h0, 1'b0);
    if (rx_q.size() >= 4) begin
      chk("b2b_tail_lane", rx_q[2].lane, 1);
      chk("b2b_head_lane", rx_q[3].lane, 3);
      chk("b2b_gap", rx_q[3].cyc - rx_q[2].cyc, 1);
    end else begin
      chk("b2b_rx_size", rx_q.size(), 10);
    end
    model_check("b2b");

    f3 = '{32'h0000_0003, 32'h4000_0000, 32'hC000_0000, 32'h0000_0002, 32'hC000_0007};
    k3 = 0; e3 = 0; vcyc3 = 0; nd3 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      v3_i = (k3 < 5);
      if (k3 < 5) d3_i = f3[k3];
      else        d3_i = 32'h0;
      #1;
      if (err3_o) e3++;
      if (vld3_o != 3'b000) vcyc3++;
      for (int p = 0; p < 3; p++) begin
        if (vld3_o[p] && rdy3_i[p]) begin
          if (nd3 == 0) begin
            chk("n3_first_lane", p, 2);
            chk("n3_first_data", dat3_o[32*p +: 32], 32'h0000_0002);
          end
          nd3++;
        end
      end
      if (v3_i && rdy3_o) k3++;
    end
    chk("n3_accepted", k3, 5);
    chk("n3_delivered", nd3, 2);
    chk("n3_valid_cycles", vcyc3, 2);
    chk("n3_errors", e3, 1);
    chk("n3_dropcnt", cnt3_o, 8'd3);

    gen_random(300);
    run_stream("rand", -1, -2, 4'h0, 1'b1);
    model_check("rand");

    for (int i = 0; i < 260; i++) tx_q.push_back({2'b11, 30'(i)});
    run_stream("sat", -1, -2, 4'h0, 1'b0);
    model_check("sat");
    chk("sat_dropcnt_ff", DropCnt_o, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
